led_bank_arbiter: RTL and testbench

Shares the single 8-LED front-panel bank among several firmware requesters (error flashers, status displays, test patterns). It falls back to the one-eye cylon idle pattern when nobody requests. Ownership is granted round-robin with a minimum visible hold time, so short events remain human-readable. An optional per-requester blink is supported. The block sits between the pattern sources and the LED output pins.

---
 rtl/led_bank_arbiter_if.sv | 29 ++
 rtl/led_bank_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_bank_arbiter_if.sv
// Purpose: groups the requester inputs and LED/grant outputs of the LED bank arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold req level until they no longer want the bank.
interface led_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int MXHOLD = 24
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_blink;
    logic [7:0]        idle_pattern;
    logic [MXHOLD-1:0] hold_cycles;
    logic [MXHOLD-1:0] blink_half;
    logic [7:0]        led;
    logic [NREQ-1:0]   grant;
    logic              owner_valid;

    // Pattern sources side
    modport master (
        output req, req_data, req_blink, idle_pattern, hold_cycles, blink_half,
        input  led, grant, owner_valid
    );

    // Arbiter side
    modport slave (
        input  req, req_data, req_blink, idle_pattern, hold_cycles, blink_half,
        output led, grant, owner_valid
    );
endinterface

// File: rtl/led_bank_arbiter.sv
// Purpose: round-robin owner of the 8-LED bank with minimum hold, per-owner blink, idle fallback.
// Latency: 1 clock from req/req_data/idle_pattern to registered led/grant/owner_valid.
// Backpressure: none; losing requesters simply wait, the owner is locked until its hold expires.
module led_bank_arbiter #(
    parameter int NREQ   = 4,
    parameter int MXHOLD = 24
) (
    input  logic               clock,
    input  logic               reset_n,
    led_bank_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              take;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [MXHOLD-1:0] hold_cnt;
    logic [MXHOLD-1:0] blink_cnt;
    logic              phase;
    logic [7:0]        latched;
    logic [7:0]        led_q;
    logic [NREQ-1:0]   grant_q;
    logic              owner_valid_q;

    logic [PW-1:0]     ptr_nxt;
    logic [PW-1:0]     owner_nxt;
    logic [MXHOLD-1:0] hold_nxt;
    logic [MXHOLD-1:0] blink_nxt;
    logic              phase_nxt;
    logic [7:0]        latched_nxt;
    logic [7:0]        led_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic              owner_valid_nxt;

    logic [NREQ-1:0]   cand;
    logic              found;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     winner_inc;
    logic [PW-1:0]     idx_b;
    int                idx;

    logic [7:0]        owner_data;
    logic [7:0]        win_data;
    logic              owner_req;
    logic              owner_blink;

    assign bus.led         = led_q;
    assign bus.grant       = grant_q;
    assign bus.owner_valid = owner_valid_q;

    // Round-robin search from ptr; the current owner is excluded so a handover always picks someone else
    always_comb begin
        cand   = (state == OWN) ? (bus.req & ~grant_q) : bus.req;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_b = PW'(idx);
            if (!found && cand[idx_b]) begin
                found  = 1'b1;
                winner = idx_b;
            end
        end
        winner_inc = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    // Select the current owner's and the search winner's request lines
    always_comb begin
        owner_data  = 8'h00;
        win_data    = 8'h00;
        owner_req   = 1'b0;
        owner_blink = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == PW'(i)) begin
                owner_data  = bus.req_data[i*8 +: 8];
                owner_req   = bus.req[i];
                owner_blink = bus.req_blink[i];
            end
            if (winner == PW'(i)) begin
                win_data = bus.req_data[i*8 +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant from IDLE on any request; once hold expires, hand over, keep, or release
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWN;
                    take      = 1'b1;
                end
            end
            OWN: begin
                if (hold_cnt == '0) begin
                    if (found) begin
                        take = 1'b1;
                    end else if (!owner_req) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; led uses the post-update blink phase so a toggle shows on the same edge
    always_comb begin
        ptr_nxt         = ptr;
        owner_nxt       = owner;
        hold_nxt        = hold_cnt;
        blink_nxt       = blink_cnt;
        phase_nxt       = phase;
        latched_nxt     = latched;
        led_nxt         = led_q;
        grant_nxt       = grant_q;
        owner_valid_nxt = owner_valid_q;
        if (take) begin
            owner_nxt         = winner;
            ptr_nxt           = winner_inc;
            hold_nxt          = bus.hold_cycles;
            blink_nxt         = '0;
            phase_nxt         = 1'b1;
            latched_nxt       = win_data;
            led_nxt           = win_data;
            grant_nxt         = '0;
            grant_nxt[winner] = 1'b1;
            owner_valid_nxt   = 1'b1;
        end else if (state_nxt == IDLE) begin
            hold_nxt        = '0;
            blink_nxt       = '0;
            phase_nxt       = 1'b1;
            led_nxt         = bus.idle_pattern;
            grant_nxt       = '0;
            owner_valid_nxt = 1'b0;
        end else begin
            if (hold_cnt != '0) begin
                hold_nxt = hold_cnt - 1'b1;
            end
            if (owner_req) begin
                latched_nxt = owner_data;
            end
            if (owner_blink) begin
                // >= keeps the counter bounded if blink_half is lowered mid-ownership
                if (blink_cnt >= bus.blink_half) begin
                    blink_nxt = '0;
                    phase_nxt = ~phase;
                end else begin
                    blink_nxt = blink_cnt + 1'b1;
                end
            end else begin
                blink_nxt = '0;
                phase_nxt = 1'b1;
            end
            led_nxt = phase_nxt ? (owner_req ? owner_data : latched) : 8'h00;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            owner         <= '0;
            hold_cnt      <= '0;
            blink_cnt     <= '0;
            phase         <= 1'b1;
            latched       <= 8'h00;
            led_q         <= 8'h00;
            grant_q       <= '0;
            owner_valid_q <= 1'b0;
        end else begin
            ptr           <= ptr_nxt;
            owner         <= owner_nxt;
            hold_cnt      <= hold_nxt;
            blink_cnt     <= blink_nxt;
            phase         <= phase_nxt;
            latched       <= latched_nxt;
            led_q         <= led_nxt;
            grant_q       <= grant_nxt;
            owner_valid_q <= owner_valid_nxt;
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Purpose: scoreboard bench for led_bank_arbiter with directed, hand-computed expectations.
// Latency: expectations queued before an edge are compared 1 time unit after it (or after async reset).
// Backpressure: n/a.
module tb_led_bank_arbiter;
    localparam int NREQ   = 4;
    localparam int MXHOLD = 24;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    led_bank_arbiter_if #(.NREQ(NREQ), .MXHOLD(MXHOLD)) bus ();

    led_bank_arbiter #(.NREQ(NREQ), .MXHOLD(MXHOLD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] led;
        logic [3:0] grant;
        logic       vld;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input logic [7:0] l, input logic [3:0] g, input string nm);
        exp_t e;
        e.led   = l;
        e.grant = g;
        e.vld   = (g != 4'b0000);
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Queue the expected outputs for the coming edge, then advance to the next negedge
    task automatic cyc(input logic [7:0] l, input logic [3:0] g, input string nm);
        expect_out(l, g, nm);
        @(negedge clock);
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or negedge reset_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.led !== e.led || bus.grant !== e.grant || bus.owner_valid !== e.vld) begin
                    errors++;
                    $display("FAIL %s: got led=%h grant=%b owner_valid=%b, want led=%h grant=%b owner_valid=%b",
                             e.name, bus.led, bus.grant, bus.owner_valid, e.led, e.grant, e.vld);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.req          = '0;
        bus.req_data     = '0;
        bus.req_blink    = '0;
        bus.idle_pattern = 8'h00;
        bus.hold_cycles  = '0;
        bus.blink_half   = '0;

        expect_out(8'h00, 4'b0000, "reset_state");
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Idle sweep: led follows idle_pattern one clock later
        for (int i = 0; i < 8; i++) begin
            bus.idle_pattern = 8'(1 << i);
            cyc(8'(1 << i), 4'b0000, $sformatf("idle_sweep%0d", i));
        end

        // Two simultaneous requesters alternate every H+1 = 4 clocks
        bus.idle_pattern = 8'h3C;
        set_data(0, 8'h11);
        set_data(1, 8'h33);
        set_data(2, 8'h22);
        set_data(3, 8'h44);
        bus.hold_cycles = 24'd3;
        bus.req         = 4'b0101;
        for (int i = 0; i < 4; i++) cyc(8'h11, 4'b0001, "rr_first");
        for (int i = 0; i < 4; i++) cyc(8'h22, 4'b0100, "rr_second");
        cyc(8'h11, 4'b0001, "rr_back");
        bus.req = 4'b0000;
        repeat (3) @(negedge clock);
        cyc(8'h3C, 4'b0000, "rr_release");

        // One-clock pulse is held for 11 clocks showing the latched pattern
        bus.hold_cycles = 24'd10;
        bus.req         = 4'b0100;
        set_data(2, 8'hA5);
        cyc(8'hA5, 4'b0100, "pulse_grant");
        bus.req = 4'b0000;
        set_data(2, 8'h00);
        for (int i = 0; i < 10; i++) cyc(8'hA5, 4'b0100, "pulse_hold");
        cyc(8'h3C, 4'b0000, "pulse_release");

        // Blink with blink_half=2: three on, three off
        set_data(1, 8'hFF);
        bus.req_blink   = 4'b0010;
        bus.blink_half  = 24'd2;
        bus.hold_cycles = 24'd0;
        bus.req         = 4'b0010;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) cyc(8'hFF, 4'b0010, "blink_on");
            for (int i = 0; i < 3; i++) cyc(8'h00, 4'b0010, "blink_off");
        end
        bus.req       = 4'b0000;
        bus.req_blink = 4'b0000;
        cyc(8'h3C, 4'b0000, "blink_release");

        // Owner drops exactly at hold expiry while another request is pending
        bus.hold_cycles = 24'd2;
        set_data(0, 8'h5A);
        set_data(3, 8'hC3);
        bus.req = 4'b0001;
        cyc(8'h5A, 4'b0001, "exp_grant");
        bus.req = 4'b1001;
        cyc(8'h5A, 4'b0001, "exp_lock");
        cyc(8'h5A, 4'b0001, "exp_lock");
        bus.req = 4'b1000;
        cyc(8'hC3, 4'b1000, "exp_handover");
        bus.req = 4'b0000;
        repeat (2) @(negedge clock);
        cyc(8'h3C, 4'b0000, "exp_release");

        // Asynchronous reset mid-hold, then search restarts at requester 0
        bus.hold_cycles = 24'd20;
        set_data(1, 8'h77);
        bus.req = 4'b0010;
        cyc(8'h77, 4'b0010, "mid_grant");
        cyc(8'h77, 4'b0010, "mid_hold");
        expect_out(8'h00, 4'b0000, "async_reset");
        #2 reset_n = 1'b0;
        bus.req = 4'b1111;
        set_data(0, 8'hE1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc(8'hE1, 4'b0001, "post_reset_grant");
        cyc(8'hE1, 4'b0001, "post_reset_hold");

        bus.req = 4'b0000;
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion earlier");
        $fatal(1, "watchdog");
    end
endmodule
